// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - FIFO of pending word stores between CPU and Data_Memory with load forwarding.
// Optional in-place store coalescing on the newest entry: STORE_BUF_COALESCE_EN.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      st_valid,
  input  logic [ADDR_W-1:0]         st_addr,
  input  logic [DATA_W-1:0]         st_data,
  output logic                      st_ready,
  input  logic                      ld_valid,
  input  logic [ADDR_W-1:0]         ld_addr,
  output logic [DATA_W-1:0]         ld_data,
  output logic                      ld_stall,
  input  logic                      flush,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count,
  output logic [ADDR_W-1:0]         mem_address,
  output logic                      mem_write_en,
  output logic [DATA_W-1:0]         mem_write_data,
  input  logic [DATA_W-1:0]         mem_read_data
);
  localparam int PW = $clog2(DEPTH);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [PW-1:0]     head, tail, last;
  logic [PW:0]       count_q;
  logic              overlap, fwd_hit, load_port, drain, push, coalesce;
  logic [DATA_W-1:0] fwd_data;
  logic [PW-1:0]     idx;

  // True when b lies 1..3 bytes above a (modulo the address space).
  function automatic logic near(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
    logic [ADDR_W-1:0] d;
    d = b - a;
    return (d != '0) && (d <= ADDR_W'(3));
  endfunction

  always_comb begin
    overlap = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (near(addr_q[i], ld_addr) || near(ld_addr, addr_q[i])))
        overlap = 1'b1;
    end
  end

  // Walk oldest to newest so the last hit is the youngest matching store.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (valid_q[idx] && addr_q[idx] == ld_addr) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end

  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign st_ready  = (count_q != (PW+1)'(DEPTH)) && !flush;
  assign ld_stall  = ld_valid && (overlap || flush);
  assign load_port = ld_valid && !overlap && !flush;
  assign drain     = !load_port && !empty;
  assign last      = tail - PW'(1);

  assign mem_address    = drain ? addr_q[head] : ld_addr;
  assign mem_write_en   = drain;
  assign mem_write_data = data_q[head];
  assign ld_data        = (ld_valid && !ld_stall && fwd_hit) ? fwd_data : mem_read_data;

`ifdef STORE_BUF_COALESCE_EN
  assign coalesce = st_valid && !flush && !empty && valid_q[last] &&
                    (addr_q[last] == st_addr) && !(drain && head == last);
`else
  assign coalesce = 1'b0;
`endif
  assign push = st_valid && st_ready && !coalesce;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (drain) begin
        valid_q[head] <= 1'b0;
        head          <= head + PW'(1);
      end
      if (push) begin
        addr_q[tail]  <= st_addr;
        data_q[tail]  <= st_data;
        valid_q[tail] <= 1'b1;
        tail          <= tail + PW'(1);
      end
      if (coalesce)
        data_q[last] <= st_data;
      if (push && !drain)
        count_q <= count_q + (PW+1)'(1);
      else if (drain && !push)
        count_q <= count_q - (PW+1)'(1);
    end
  end
endmodule
